// File: rtl/clk_div_pkg.sv
// Shared encodings, FSM states and half-period lookup for the
// glitch-free clock divider controller.
package clk_div_pkg;

    localparam logic [1:0] SEL_DIV2  = 2'b00;
    localparam logic [1:0] SEL_DIV4  = 2'b01;
    localparam logic [1:0] SEL_DIV64 = 2'b10;
    localparam logic [1:0] SEL_STOP  = 2'b11;

    localparam int HM1_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    // Half period minus one; STOP has no period and maps to 0.
    function automatic logic [HM1_W-1:0] half_m1(input logic [1:0] sel);
        logic [HM1_W-1:0] v;
        case (sel)
            SEL_DIV2:  v = 6'd0;
            SEL_DIV4:  v = 6'd1;
            SEL_DIV64: v = 6'd31;
            default:   v = 6'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_core.sv
// Half-period down-counter and output toggle flop; load and stop
// always leave the output low so phases only start from a low level.
module clk_div_core #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic             stop,
    input  logic [CNT_W-1:0] reload,
    output logic             gen,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    assign wrap = run && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            gen <= 1'b0;
        end else if (load) begin
            cnt <= reload;
            gen <= 1'b0;
        end else if (stop) begin
            cnt <= '0;
            gen <= 1'b0;
        end else if (wrap) begin
            cnt <= reload;
            gen <= ~gen;
        end else if (run) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divide-ratio controller: ratio changes are applied on falling edges
// of o_gen_clk only. o_tick exists when CLK_DIV_CTRL_TICK_EN is defined.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic [1:0] i_sel,
    output logic       o_busy,
    output logic       o_ack,
    output logic [1:0] o_cur_sel,
    output logic       o_gen_clk
`ifdef CLK_DIV_CTRL_TICK_EN
    ,
    output logic       o_tick
`endif
);

    state_e           state, state_nxt;
    logic [1:0]       cur_q, cur_nxt;
    logic [1:0]       pend_q, pend_nxt;
    logic             ack_q, ack_nxt;
    logic             load, stop, run, wrap, gen;
    logic [CNT_W-1:0] reload;

    assign run = (state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            cur_q  <= SEL_STOP;
            pend_q <= SEL_STOP;
            ack_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cur_q  <= cur_nxt;
            pend_q <= pend_nxt;
            ack_q  <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_q;
        pend_nxt  = pend_q;
        ack_nxt   = 1'b0;
        load      = 1'b0;
        stop      = 1'b0;
        reload    = CNT_W'(half_m1(cur_q));
        case (state)
            ST_IDLE: begin
                if (i_req) begin
                    ack_nxt = 1'b1;
                    if (i_sel != SEL_STOP) begin
                        load      = 1'b1;
                        reload    = CNT_W'(half_m1(i_sel));
                        cur_nxt   = i_sel;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_req) begin
                    pend_nxt  = i_sel;
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                // Falling edge of the output: safe point to switch.
                if (wrap && gen) begin
                    ack_nxt = 1'b1;
                    if (pend_q == SEL_STOP) begin
                        stop      = 1'b1;
                        cur_nxt   = SEL_STOP;
                        state_nxt = ST_IDLE;
                    end else begin
                        load      = 1'b1;
                        reload    = CNT_W'(half_m1(pend_q));
                        cur_nxt   = pend_q;
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    clk_div_core #(.CNT_W(CNT_W)) u_core (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .run    (run),
        .load   (load),
        .stop   (stop),
        .reload (reload),
        .gen    (gen),
        .wrap   (wrap)
    );

    assign o_busy    = (state == ST_PEND);
    assign o_ack     = ack_q;
    assign o_cur_sel = cur_q;
    assign o_gen_clk = gen;

`ifdef CLK_DIV_CTRL_TICK_EN
    logic tick_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap && !gen;
        end
    end

    assign o_tick = tick_q;
`endif

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 6: width of the half-period counter; it must hold 31.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port i_req, input, 1 bit: request to change the divide ratio.
REQ-005 SHALL have port i_sel, input, 2 bits: ratio select; 00 = div2, 01 = div4, 10 = div64, 11 = STOP.
REQ-006 SHALL have port o_busy, output, 1 bit: a request is pending and new requests are ignored.
REQ-007 SHALL have port o_ack, output, 1 bit: one-cycle pulse that completes a request.
REQ-008 SHALL have port o_cur_sel, output, 2 bits: the ratio currently in effect.
REQ-009 SHALL have port o_gen_clk, output, 1 bit: the generated clock.
REQ-010 SHALL have port o_tick, output, 1 bit: one-cycle pulse in the cycle after each o_gen_clk rising edge; present only under the macro in REQ-025.

Function
REQ-011 SHALL define the half period H, in i_clk cycles, as div2 = 1, div4 = 2, div64 = 32; o_gen_clk toggles every H cycles and has a 50% duty cycle.
REQ-012 SHALL use three states:
- IDLE: o_gen_clk held at 0.
- RUN: dividing at the current ratio.
- PEND: running, with a change waiting.
REQ-013 SHALL accept a request only on an edge where i_req = 1 and o_busy = 0; i_sel is latched at that edge, and i_sel is ignored at all other times.
REQ-014 SHALL handle a non-STOP request accepted in IDLE at edge t as follows:
- the counter is loaded with H-1;
- the state goes to RUN;
- o_cur_sel is updated;
- o_ack = 1 during the cycle after edge t;
- o_gen_clk first rises at edge t+H.
REQ-015 SHALL handle a STOP request accepted in IDLE by staying in IDLE, pulsing o_ack one cycle later, and leaving o_gen_clk at 0.
REQ-016 SHALL handle a request accepted in RUN by moving to PEND with o_busy = 1; o_gen_clk keeps its current ratio until its next high-to-low edge.
REQ-017 SHALL apply a pending request at that high-to-low edge, so no high or low phase is ever shortened (glitch-free):
- non-STOP: the counter reloads with the new H-1, o_cur_sel updates, and the state returns to RUN;
- STOP: o_gen_clk stays 0 and the state goes to IDLE, with o_cur_sel = 11.
REQ-018 SHALL pulse o_ack for exactly one cycle, in the cycle after the request is applied, and deassert o_busy in that same cycle.
REQ-019 SHALL, when the pending select equals the current select, still go through PEND and acknowledge at the next falling edge, with the period unchanged.
REQ-020 SHALL accept a request in the o_ack cycle itself, because o_busy is already 0.
REQ-021 SHALL decrement the counter modulo H: on reaching 0 it reloads H-1 and o_gen_clk toggles, with no wrap through 2^CNT_W.

Reset
REQ-022 SHALL, when i_rst_n = 0 at a rising edge, set the state to IDLE, the counter to 0, o_gen_clk/o_busy/o_ack/o_tick to 0, and o_cur_sel to 11.
REQ-023 SHALL let reset take priority over any pending request, which is discarded without an o_ack.
REQ-024 SHALL, when reset is asserted mid-phase, drive o_gen_clk to 0 on the next edge, even if this truncates the high phase.

Configuration
REQ-025 SHALL gate o_tick with the macro CLK_DIV_CTRL_TICK_EN:
- defined: o_tick port and its logic are present;
- undefined: port and logic are absent, and all other behaviour is identical.

Structure
REQ-026 SHALL place the following in shared package clk_div_pkg:
- the select encodings (SEL_DIV2, SEL_DIV4, SEL_DIV64, SEL_STOP);
- the state enum;
- the function mapping a select to H-1.
REQ-027 SHALL instantiate one sub-module, clk_div_core, which holds the counter and the toggle flop and takes a reload value and a load strobe; the FSM stays in clk_div_ctrl.

Verification
REQ-028 SHALL cover reset then a div4 request at edge 10: o_ack is high in cycle 11, o_gen_clk rises at edge 12, and the period is 4 cycles.
REQ-029 SHALL cover running div2, then requesting div64 while o_gen_clk is high: o_busy is high until the next falling edge, after which the low phase lasts 32 cycles and o_ack pulses once.
REQ-030 SHALL cover running div64, then requesting STOP: the high phase completes its full 32 cycles, then o_gen_clk = 0, the state is IDLE, and o_cur_sel = 11.
REQ-031 SHALL cover a second i_req asserted while o_busy = 1: it is ignored, so there is no extra o_ack and o_cur_sel reflects only the first request.
REQ-032 SHALL cover i_rst_n = 0 during PEND: no o_ack, and o_gen_clk = 0 on the next edge; with CLK_DIV_CTRL_TICK_EN defined, o_tick pulses once per period in div4.
